// File: rtl/mux_nch_reg_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
// The package name is mux_pkg; the file carries the block name so it sorts with its siblings.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wrap-around increment modulo n. Any idx at or past n-1 wraps to 0.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx >= n - 1) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/mux_nch_reg_if.sv
// Bus bundle for mux_nch_reg: producer channels, consumer side, select control and debug view.
interface mux_nch_reg_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
);
  // Handshake rule: a word moves on a channel (in_valid[k] && in_ready[k]) or on the output
  // (out_valid && out_ready) only at a rising edge where both are high; valid never waits on ready.
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      sel_load;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;
  logic [SEL_W-1:0]          dbg_sel_reg;
  logic [SEL_W-1:0]          dbg_rr_ptr;

  modport master (
    output mode, sel, sel_load, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err, dbg_sel_reg, dbg_rr_ptr
  );

  modport slave (
    input  mode, sel, sel_load, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err, dbg_sel_reg, dbg_rr_ptr
  );
endinterface

// File: rtl/mux_nch_reg_rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, with ptr itself checked last.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = int'(ptr);
    for (int i = 0; i < CHANNELS; i++) begin
      k = wrap_inc(k, CHANNELS);
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = SEL_W'(k);
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel mux with fixed or round-robin selection feeding a single registered output stage.
module mux_nch_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst,
  mux_nch_reg_if.slave   bus
);

  logic [SEL_W-1:0]    sel_reg;
  logic [SEL_W-1:0]    rr_ptr;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_ch_q;
  logic                out_valid_q;
  logic                sel_err_q;

  logic                load_en;
  logic                grant;
  logic [SEL_W-1:0]    cand;
  logic [WIDTH-1:0]    cand_data;
  logic [CHANNELS-1:0] ready;
  logic                sel_ok;

  logic [CHANNELS-1:0] rr_gnt;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req (bus.in_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Candidate and grant are computed from valids and pointers only, never from data.
  always_comb begin
    load_en   = !out_valid_q || bus.out_ready;
    cand      = sel_reg;
    grant     = 1'b0;
    cand_data = '0;
    ready     = '0;
    if (bus.mode == MODE_RR) begin
      cand  = rr_idx;
      grant = rr_any;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel_reg == SEL_W'(k)) grant = bus.in_valid[k];
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (cand == SEL_W'(k)) begin
        cand_data = bus.in_data[k*WIDTH +: WIDTH];
        ready[k]  = load_en && grant;
      end
    end
  end

  assign sel_ok = ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
      sel_reg     <= '0;
      rr_ptr      <= SEL_W'(CHANNELS - 1);
    end else begin
      if (load_en) begin
        if (grant) begin
          out_data_q  <= cand_data;
          out_ch_q    <= cand;
          out_valid_q <= 1'b1;
          if (bus.mode == MODE_RR) rr_ptr <= cand;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      // Out-of-range loads are rejected and latched as an error until reset.
      if (bus.sel_load) begin
        if (sel_ok) sel_reg <= bus.sel;
        else        sel_err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.dbg_sel_reg = sel_reg;
  assign bus.dbg_rr_ptr  = rr_ptr;

endmodule

// File: tb/tb_mux_nch_reg.sv
// Directed bench for mux_nch_reg: a 4-channel instance plus a 3-channel instance for range checks.
module tb_mux_nch_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mux_nch_reg_if #(.WIDTH(2), .CHANNELS(4)) a ();
  mux_nch_reg_if #(.WIDTH(2), .CHANNELS(3)) b ();

  mux_nch_reg #(.WIDTH(2), .CHANNELS(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  mux_nch_reg #(.WIDTH(2), .CHANNELS(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  // Advance one edge and step clear of it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a.mode = 1'b0; a.sel = '0; a.sel_load = 1'b0; a.in_data = '0; a.in_valid = '0; a.out_ready = 1'b1;
    b.mode = 1'b0; b.sel = '0; b.sel_load = 1'b0; b.in_data = '0; b.in_valid = '0; b.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (a.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", a.out_valid); else n_pass++;
    n_total++; if (a.out_data !== 2'b00) $display("FAIL reset_out_data got=%0d exp=0", a.out_data); else n_pass++;
    n_total++; if (a.out_ch !== 2'd0) $display("FAIL reset_out_ch got=%0d exp=0", a.out_ch); else n_pass++;
    n_total++; if (a.sel_err !== 1'b0) $display("FAIL reset_sel_err got=%0b exp=0", a.sel_err); else n_pass++;
    n_total++; if (a.dbg_rr_ptr !== 2'd3) $display("FAIL reset_rr_ptr got=%0d exp=3", a.dbg_rr_ptr); else n_pass++;
    n_total++; if (b.dbg_rr_ptr !== 2'd2) $display("FAIL reset_rr_ptr_b got=%0d exp=2", b.dbg_rr_ptr); else n_pass++;
  endtask

  task automatic test_fixed();
    a.mode = 1'b0; a.sel = 2'd2; a.sel_load = 1'b1; a.in_valid = 4'b0000;
    tick();
    a.sel_load = 1'b0;
    n_total++; if (a.dbg_sel_reg !== 2'd2) $display("FAIL fixed_sel_reg got=%0d exp=2", a.dbg_sel_reg); else n_pass++;
    a.in_data = 8'b00_11_10_01; a.in_valid = 4'b0100;
    #1;
    n_total++; if (a.in_ready !== 4'b0100) $display("FAIL fixed_in_ready got=%b exp=0100", a.in_ready); else n_pass++;
    tick();
    n_total++; if (a.out_valid !== 1'b1) $display("FAIL fixed_out_valid got=%0b exp=1", a.out_valid); else n_pass++;
    n_total++; if (a.out_data !== 2'b11) $display("FAIL fixed_out_data got=%b exp=11", a.out_data); else n_pass++;
    n_total++; if (a.out_ch !== 2'd2) $display("FAIL fixed_out_ch got=%0d exp=2", a.out_ch); else n_pass++;
    n_total++; if (a.dbg_rr_ptr !== 2'd3) $display("FAIL fixed_rr_ptr_kept got=%0d exp=3", a.dbg_rr_ptr); else n_pass++;
    a.in_valid = 4'b0000;
    tick();
    n_total++; if (a.out_valid !== 1'b0) $display("FAIL fixed_drain got=%0b exp=0", a.out_valid); else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
    a.mode = 1'b1; a.in_data = {2'd3, 2'd2, 2'd1, 2'd0}; a.in_valid = 4'b1111; a.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++; if (a.out_valid !== 1'b1 || a.out_ch !== 2'(exp_ch[i]) || a.out_data !== 2'(exp_ch[i]))
        $display("FAIL rr_full[%0d] got v=%0b ch=%0d d=%0d exp v=1 ch=%0d d=%0d", i, a.out_valid, a.out_ch, a.out_data, exp_ch[i], exp_ch[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rr_sparse();
    int exp_ch [4] = '{3, 1, 3, 1};
    logic [3:0] exp_rdy;
    a.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_rdy = (exp_ch[i] == 3) ? 4'b1000 : 4'b0010;
      n_total++; if (a.in_ready !== exp_rdy) $display("FAIL rr_sparse_ready[%0d] got=%b exp=%b", i, a.in_ready, exp_rdy); else n_pass++;
      tick();
      n_total++; if (a.out_ch !== 2'(exp_ch[i]) || a.out_data !== 2'(exp_ch[i]))
        $display("FAIL rr_sparse_out[%0d] got ch=%0d d=%0d exp ch=%0d d=%0d", i, a.out_ch, a.out_data, exp_ch[i], exp_ch[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] stall_data  [3] = '{8'hFF, 8'h00, 8'hA5};
    logic [3:0] stall_valid [3] = '{4'b1111, 4'b0001, 4'b1000};
    a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a.in_data = stall_data[i]; a.in_valid = stall_valid[i];
      #1;
      n_total++; if (a.in_ready !== 4'b0000) $display("FAIL stall_ready[%0d] got=%b exp=0000", i, a.in_ready); else n_pass++;
      tick();
      n_total++; if (a.out_valid !== 1'b1 || a.out_ch !== 2'd1 || a.out_data !== 2'd1)
        $display("FAIL stall_hold[%0d] got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=1", i, a.out_valid, a.out_ch, a.out_data);
      else n_pass++;
    end
    a.out_ready = 1'b1; a.in_data = 8'b00_01_10_11; a.in_valid = 4'b1111;
    #1;
    n_total++; if (a.in_ready !== 4'b0100) $display("FAIL release_ready got=%b exp=0100", a.in_ready); else n_pass++;
    tick();
    n_total++; if (a.out_ch !== 2'd2 || a.out_data !== 2'b01)
      $display("FAIL release_out got ch=%0d d=%b exp ch=2 d=01", a.out_ch, a.out_data);
    else n_pass++;
  endtask

  task automatic test_fixed_starve();
    a.mode = 1'b0; a.sel = 2'd1; a.sel_load = 1'b1; a.in_data = 8'b00_10_01_00; a.in_valid = 4'b0100;
    #1;
    n_total++; if (a.in_ready !== 4'b0100) $display("FAIL old_sel_ready got=%b exp=0100", a.in_ready); else n_pass++;
    tick();
    a.sel_load = 1'b0;
    n_total++; if (a.out_ch !== 2'd2 || a.out_data !== 2'b10 || a.dbg_sel_reg !== 2'd1)
      $display("FAIL old_sel_xfer got ch=%0d d=%b sel_reg=%0d exp ch=2 d=10 sel_reg=1", a.out_ch, a.out_data, a.dbg_sel_reg);
    else n_pass++;
    #1;
    n_total++; if (a.in_ready !== 4'b0000) $display("FAIL starve_ready got=%b exp=0000", a.in_ready); else n_pass++;
    tick();
    n_total++; if (a.out_valid !== 1'b0) $display("FAIL starve_drop got=%0b exp=0", a.out_valid); else n_pass++;
    tick();
    n_total++; if (a.out_valid !== 1'b0) $display("FAIL starve_idle got=%0b exp=0", a.out_valid); else n_pass++;
    a.in_valid = 4'b0010;
    #1;
    n_total++; if (a.in_ready !== 4'b0010) $display("FAIL resume_ready got=%b exp=0010", a.in_ready); else n_pass++;
    tick();
    n_total++; if (a.out_valid !== 1'b1 || a.out_ch !== 2'd1 || a.out_data !== 2'b01)
      $display("FAIL resume_out got v=%0b ch=%0d d=%b exp v=1 ch=1 d=01", a.out_valid, a.out_ch, a.out_data);
    else n_pass++;
    n_total++; if (a.dbg_rr_ptr !== 2'd2) $display("FAIL fixed_rr_ptr_frozen got=%0d exp=2", a.dbg_rr_ptr); else n_pass++;
  endtask

  task automatic test_sel_err();
    int exp_ch [4] = '{0, 1, 2, 0};
    b.sel = 2'd1; b.sel_load = 1'b1;
    tick();
    n_total++; if (b.dbg_sel_reg !== 2'd1) $display("FAIL b_sel_load got=%0d exp=1", b.dbg_sel_reg); else n_pass++;
    b.sel = 2'd3;
    tick();
    n_total++; if (b.sel_err !== 1'b1 || b.dbg_sel_reg !== 2'd1)
      $display("FAIL b_sel_oob got err=%0b sel_reg=%0d exp err=1 sel_reg=1", b.sel_err, b.dbg_sel_reg);
    else n_pass++;
    b.sel = 2'd2;
    tick();
    b.sel_load = 1'b0;
    n_total++; if (b.sel_err !== 1'b1 || b.dbg_sel_reg !== 2'd2)
      $display("FAIL b_sel_sticky got err=%0b sel_reg=%0d exp err=1 sel_reg=2", b.sel_err, b.dbg_sel_reg);
    else n_pass++;
    b.mode = 1'b1; b.in_data = {2'd2, 2'd1, 2'd0}; b.in_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (b.out_ch !== 2'(exp_ch[i]) || b.out_data !== 2'(exp_ch[i]))
        $display("FAIL b_rr_wrap[%0d] got ch=%0d d=%0d exp ch=%0d d=%0d", i, b.out_ch, b.out_data, exp_ch[i], exp_ch[i]);
      else n_pass++;
    end
    b.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (b.sel_err !== 1'b0 || b.out_valid !== 1'b0 || b.dbg_sel_reg !== 2'd0)
      $display("FAIL b_rst got err=%0b v=%0b sel_reg=%0d exp err=0 v=0 sel_reg=0", b.sel_err, b.out_valid, b.dbg_sel_reg);
    else n_pass++;
    n_total++; if (a.out_valid !== 1'b0) $display("FAIL a_rst_discard got=%0b exp=0", a.out_valid); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_rr_sparse();
    test_backpressure();
    test_fixed_starve();
    test_sel_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_nch_reg.md
Name: mux_nch_reg

Overview:
- Parametrised successor to the team's 2:1 combinational bit-mux.
- Selects one of CHANNELS input channels, each WIDTH bits wide, and presents the chosen word on a registered output stage with a valid/ready handshake.
- Two selection modes:
  - fixed: a software-loaded select register picks the channel.
  - round-robin: the block scans across channels that have valid data.
- Sits between multiple producer channels and a single downstream consumer.

Parameters:
- WIDTH, 2, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin scan.
- sel  in  SEL_W  channel index for fixed mode.
- sel_load  in  1  when high, sel is written into the select register at the edge.
- in_data  in  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel accept; one-hot or zero.
- out_data  out  WIDTH  registered selected word.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  out_data/out_ch hold a word.
- out_ready  in  1  consumer accepts the word.
- sel_err  out  1  sticky flag: a sel_load was attempted with sel >= CHANNELS.

Behaviour:
- Reset values (rst high at an edge):
  - out_valid = 0, out_data = 0, out_ch = 0, sel_err = 0.
  - sel_reg = 0.
  - rr_ptr = CHANNELS-1, so the first round-robin search starts at channel 0.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is high.
- Grant logic (combinational, same cycle):
  - Fixed mode: candidate c = sel_reg. grant = in_valid[c].
  - Round-robin mode: c = first k with in_valid[k] high, searching rr_ptr+1, rr_ptr+2, ... with wrap modulo CHANNELS. rr_ptr itself is checked last. grant = any in_valid high.
- in_ready[c] = load_en && grant. All other in_ready bits are 0. in_ready must not depend on in_data.
- On an edge with load_en && grant:
  - out_data <= channel c data, out_ch <= c, out_valid <= 1.
  - In round-robin mode only, rr_ptr <= c.
- On an edge with load_en && !grant: out_valid <= 0; out_data and out_ch hold their last values.
- On an edge with !load_en: out_data, out_ch and out_valid hold (backpressure). No in_ready is asserted.
- Latency: 1 cycle from input handshake to out_valid. Full throughput of 1 word per cycle when out_ready is held high.
- sel_load:
  - sel < CHANNELS: sel_reg <= sel at the edge; it governs selection from the next cycle.
  - sel >= CHANNELS: sel_reg is unchanged and sel_err <= 1. sel_err stays set until rst.
- mode change: sampled every cycle, so the new mode applies to that cycle's grant. rr_ptr is preserved across mode changes and is not updated while in fixed mode.
- Simultaneous sel_load and a fixed-mode transfer in the same cycle: the transfer uses the old sel_reg.
- rst mid-transfer: any held word is discarded and out_valid = 0 on the next cycle. rst has priority over all other updates.
- CHANNELS not a power of two: indices >= CHANNELS are never granted.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - Helper function for the wrap-around increment modulo CHANNELS.
- Sub-module rr_arbiter (parameter CHANNELS):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, binary index, any flag.
  - Purely combinational.
- mux_nch_reg keeps the select register, rr_ptr, the output register and the handshake logic.

Test Plan:
- Reset, then mode=0, sel_load with sel=2, in_valid=4'b0100, channel 2 data=2'b11, out_ready=1 -> next cycle out_valid=1, out_data=2'b11, out_ch=2; in_ready=4'b0100 during the transfer cycle.
- Round-robin, all in_valid=4'b1111, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1, each with that channel's data.
- Round-robin, in_valid=4'b1010 -> out_ch alternates 1,3; channels 0 and 2 never get in_ready.
- out_valid=1 with out_ready=0 for 3 cycles while inputs change -> out_data/out_ch are stable and in_ready=0; on the first out_ready=1 cycle the next word loads.
- Using CHANNELS=3: sel_load with sel=3 -> sel_err=1 and sel_reg unchanged; then sel_load with sel=1 -> sel_err stays 1; assert rst -> sel_err=0 and out_valid=0 on the next cycle.
- Fixed mode with sel_reg=1 and in_valid[1]=0 -> out_valid drops to 0 after the current word is consumed; assert in_valid[1] -> transfer resumes with 1-cycle latency.
